// File: rtl/axi_pkg.sv
// Shared AXI3 constants, bridge state encoding and the write-strobe decode
// used by the SRAM-like to AXI3 bridge.
package axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic [3:0] strb_decode(
    input logic [1:0] size,
    input logic [1:0] lsb
  );
    logic [3:0] s;
    s = 4'b1111;
    unique case (1'b1)
      (size == SIZE_BYTE): s = 4'b0001 << lsb;
      (size == SIZE_HALF): s = lsb[1] ? 4'b1100 : 4'b0011;
      default:             s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Data-cache SRAM-like responder issuing one single-beat AXI3 access at a time.
// Optional SRAM_AXI_ERR_EN: sticky bus_err on non-OKAY R/B responses.
module sram_axi_bridge
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0]   RD_ID    = 4'd0,
  parameter logic [ID_WIDTH-1:0]   WR_ID    = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata_axi,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_WIDTH-1:0] wid,
  output logic [31:0]         wdata_axi,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                bus_err
);

  state_t      state_q, state_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_now, w_now;
  logic        r_hs, b_hs;
  logic        unused;

  assign r_hs   = rready & rvalid;
  assign b_hs   = bready & bvalid;
  assign aw_now = aw_done_q | (awvalid & awready);
  assign w_now  = w_done_q | (wvalid & wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= SIZE_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (state_q == IDLE && req) begin
        wr_q    <= wr;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    case (state_q)
      IDLE: begin
        addr_ok = req & ~rst;
        if (req)
          state_d = wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        if (arready)
          state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          data_ok = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        // both halves done, possibly this very cycle: flags rearm for next write
        if (aw_now && w_now) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          data_ok = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_axi;

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state_q == WR_REQ) & ~aw_done_q;

  assign wid       = WR_ID;
  assign wdata_axi = wdata_q;
  assign wstrb     = strb_decode(size_q, addr_q[1:0]);
  assign wlast     = 1'b1;
  assign wvalid    = (state_q == WR_REQ) & ~w_done_q;
  assign bready    = (state_q == WR_RESP);

`ifdef SRAM_AXI_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)
      bus_err <= 1'b0;
    else if ((r_hs && rresp != AXI_RESP_OKAY) ||
             (b_hs && bresp != AXI_RESP_OKAY))
      bus_err <= 1'b1;
  end
  assign unused = ^{rid, bid, rlast, wr_q};
`else
  assign bus_err = 1'b0;
  assign unused  = ^{rid, bid, rlast, wr_q, rresp, bresp, r_hs, b_hs};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a small delay-programmable AXI slave.
// Build with SRAM_AXI_ERR_EN to exercise the sticky bus_err path.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
  logic [3:0]  arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, bus_err;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // slave model
  int          aw_lat = 0, w_lat = 0, r_lat = 0;
  int          aw_wait, w_wait, r_wait;
  logic        r_pend, aw_h, w_h, b_v;
  logic [31:0] rd_val = '0;
  logic [1:0]  bresp_v = 2'b00;
  logic        a_n, w_n;

  assign arready   = arvalid;
  assign awready   = awvalid && (aw_wait >= aw_lat);
  assign wready    = wvalid && (w_wait >= w_lat);
  assign rvalid    = r_pend && (r_wait == 0);
  assign rdata_axi = rd_val;
  assign rresp     = 2'b00;
  assign rlast     = 1'b1;
  assign rid       = 4'd0;
  assign bid       = 4'd1;
  assign bvalid    = b_v;
  assign bresp     = bresp_v;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; r_wait <= 0;
      r_pend <= 1'b0; aw_h <= 1'b0; w_h <= 1'b0; b_v <= 1'b0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (arvalid && arready) begin
        r_pend <= 1'b1;
        r_wait <= r_lat;
      end else if (rvalid && rready)
        r_pend <= 1'b0;
      else if (r_pend && r_wait > 0)
        r_wait <= r_wait - 1;
      a_n = aw_h | (awvalid & awready);
      w_n = w_h | (wvalid & wready);
      if (a_n && w_n) begin
        b_v <= 1'b1; aw_h <= 1'b0; w_h <= 1'b0;
      end else begin
        aw_h <= a_n; w_h <= w_n;
      end
      if (b_v && bready) b_v <= 1'b0;
    end
  end

  int overlap = 0;
  always @(posedge clk)
    if (arvalid && (awvalid || wvalid)) overlap++;

  // per-transaction observations
  int          acc, done, ar_first, aw_cyc, w_cyc, w_beats;
  logic [31:0] rd_seen, araddr_s, wstrb_s;
  logic [2:0]  arsize_s, awsize_s;

  task automatic xact(input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    int cyc;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    cyc = 0; acc = -1; done = -1; ar_first = -1;
    aw_cyc = -1; w_cyc = -1; w_beats = 0;
    while (done < 0 && cyc < 50) begin
      #1;
      if (addr_ok && acc < 0) acc = cyc;
      if (arvalid && ar_first < 0) begin
        ar_first = cyc; araddr_s = araddr; arsize_s = arsize;
      end
      if (awvalid && awready) begin aw_cyc = cyc; awsize_s = awsize; end
      if (wvalid && wready) begin
        w_cyc = cyc; w_beats++; wstrb_s = {28'd0, wstrb};
      end
      if (data_ok) begin done = cyc; rd_seen = rdata; end
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    if (done < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  logic exp_err;

  initial begin
`ifdef SRAM_AXI_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid | wvalid | bready | rready}, 32'd0);
    chk("rst_dataok", {31'd0, data_ok}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait word read
    rd_val = 32'hDEADBEEF;
    xact(1'b0, 2'b10, 32'h1000_0004, 32'h0);
    chk("rd_acc", acc, 0);
    chk("rd_ar_cyc", ar_first, 1);
    chk("rd_araddr", araddr_s, 32'h1000_0004);
    chk("rd_arsize", {29'd0, arsize_s}, 32'd2);
    chk("rd_arid", {28'd0, arid}, 32'd0);
    chk("rd_done", done, 2);
    chk("rd_rdata", rd_seen, 32'hDEADBEEF);
    #1 chk("rd_dataok_drop", {31'd0, data_ok}, 32'd0);

    // word write, AW late by 3 cycles
    aw_lat = 3;
    xact(1'b1, 2'b10, 32'h2000_0000, 32'h1122_3344);
    chk("wr_w_cyc", w_cyc, 1);
    chk("wr_aw_cyc", aw_cyc, 4);
    chk("wr_beats", w_beats, 1);
    chk("wr_strb", wstrb_s, 32'hF);
    chk("wr_done", done, 5);
    chk("wr_wdata", wdata_axi, 32'h1122_3344);
    chk("wr_awid", {28'd0, awid}, 32'd1);
    #1 chk("wr_dataok_drop", {31'd0, data_ok}, 32'd0);
    aw_lat = 0;
    @(negedge clk);

    // byte and half writes
    xact(1'b1, 2'b00, 32'h3000_0003, 32'hAA00_0000);
    chk("byte_strb", wstrb_s, 32'h8);
    chk("byte_awsize", {29'd0, awsize_s}, 32'd0);
    chk("byte_done", done, 2);
    @(negedge clk);
    xact(1'b1, 2'b01, 32'h3000_0002, 32'hBBBB_0000);
    chk("half_strb", wstrb_s, 32'hC);
    chk("half_awsize", {29'd0, awsize_s}, 32'd1);
    @(negedge clk);

    // write-back immediately followed by refill
    overlap = 0;
    rd_val = 32'hCAFE_F00D;
    xact(1'b1, 2'b10, 32'h4000_0040, 32'h5555_AAAA);
    chk("wb_done", done, 2);
    xact(1'b0, 2'b10, 32'h4000_0080, 32'h0);
    chk("rf_acc", acc, 0);
    chk("rf_done", done, 2);
    chk("rf_rdata", rd_seen, 32'hCAFE_F00D);
    chk("rf_araddr", araddr_s, 32'h4000_0080);
    chk("overlap", overlap, 0);
    @(negedge clk);

    // reset while waiting in RD_DATA
    r_lat = 100;
    req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h5000_0000;
    repeat (2) @(negedge clk);
    #1 chk("mid_rready", {31'd0, rready & ~rvalid}, 32'd1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("mid_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_rready0", {31'd0, rready}, 32'd0);
    chk("mid_dataok", {31'd0, data_ok}, 32'd0);
    rst = 1'b0; r_lat = 0;
    @(negedge clk);
    rd_val = 32'h0BAD_F00D;
    xact(1'b0, 2'b10, 32'h5000_0010, 32'h0);
    chk("post_rst_done", done, 2);
    chk("post_rst_rdata", rd_seen, 32'h0BAD_F00D);
    @(negedge clk);

    // error response
    bresp_v = 2'b10;
    xact(1'b1, 2'b10, 32'h6000_0000, 32'h1);
    chk("err_done", done, 2);
    chk("err_flag", {31'd0, bus_err}, {31'd0, exp_err});
    bresp_v = 2'b00;
    @(negedge clk);
    xact(1'b1, 2'b10, 32'h6000_0004, 32'h2);
    chk("err_sticky", {31'd0, bus_err}, {31'd0, exp_err});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_clear", {31'd0, bus_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Responder end of the SRAM-like data interface driven by the data cache: `cache_data_req`/`wr`/`size`/`addr`/`wdata` in, `addr_ok`/`data_ok`/`rdata` out.
- Converts each accepted request into one single-beat AXI3 read or write transaction.
- Sits between the data cache and the AXI crossbar/memory.
- Exactly one transaction outstanding at a time; no reordering.

Parameters:
- ID_WIDTH, 4, width of the AXI ID fields.
- RD_ID, 4'd0, value driven on arid.
- WR_ID, 4'd1, value driven on awid; also the expected bid.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  SRAM-like request valid; requester holds it until data_ok.
- wr  in  1  1 = write, 0 = read.
- size  in  2  00 byte, 01 half, 10 word.
- addr  in  32  byte address.
- wdata  in  32  write data, lanes already positioned.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  one-cycle completion pulse.
- rdata  out  32  read data, valid only while data_ok is high on a read.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI3 read-address channel.
- arready  in  1.
- rid/rdata_axi/rresp/rlast/rvalid  in  AXI read-data channel.
- rready  out  1.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  AXI3 write-address channel.
- awready  in  1.
- wid/wdata_axi/wstrb/wlast/wvalid  out  AXI write-data channel.
- wready  in  1.
- bid/bresp/bvalid  in  AXI write-response channel.
- bready  out  1.
- bus_err  out  1  sticky error flag; see Optional Feature.

Behaviour:
- Reset values: all valids and readys 0; addr_ok 0; data_ok 0; state IDLE; bus_err 0.
- Reset mid-transaction abandons it; outputs take reset values the cycle after rst is sampled.
- State machine:
  - IDLE:
    - addr_ok = req, combinational.
    - On req: latch wr, size, addr, wdata.
    - Next state RD_ADDR if wr=0, otherwise WR_REQ.
  - RD_ADDR: arvalid=1. On arready go to RD_DATA.
  - RD_DATA: rready=1. On rvalid: data_ok=1 the same cycle, rdata = rdata_axi (combinational pass-through), next state IDLE.
  - WR_REQ:
    - awvalid=~aw_done, wvalid=~w_done.
    - Each flag sets on its own handshake.
    - AW and W may complete in either order or in the same cycle.
    - When both are done (including completion in the current cycle), go to WR_RESP and clear both flags.
  - WR_RESP: bready=1. On bvalid: data_ok=1, next state IDLE.
- Minimum latency: read = accept + 1 AR cycle + 1 R cycle, so data_ok 2 cycles after acceptance with a zero-wait slave. Write = 2 cycles with the same zero-wait slave.
- data_ok is high only for the cycle of the R or B handshake.
- The requester drops req combinationally on data_ok. A req present in the IDLE cycle after completion is a new transaction, so back-to-back write-back then refill works.
- AXI constants:
  - len=0, burst=INCR (2'b01), lock=0, cache=0, prot=0.
  - wlast=1, wid=WR_ID.
  - ar/awsize = {1'b0, latched size}.
  - ar/awaddr = latched addr unmodified.
- wstrb:
  - size 00 → 4'b0001 << addr[1:0].
  - size 01 → addr[1] ? 1100 : 0011.
  - size 10/11 → 1111.
- All AXI outputs are driven from registered state or latched fields; no AXI output depends combinationally on req.
- rid and bid are not checked; at one outstanding transaction any ID is accepted.

Optional Feature:
- Macro SRAM_AXI_ERR_EN.
- Defined: bus_err is set on any R or B handshake with resp != 2'b00. It stays set until rst. data_ok still pulses and rdata still passes through.
- Undefined: resp is ignored and bus_err is tied 0.

Decomposition:
- Shared package `axi_pkg` holds:
  - state encoding: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP;
  - AXI_BURST_INCR, AXI_RESP_OKAY;
  - SIZE_BYTE/HALF/WORD;
  - a strobe-decode function.
- No sub-module; the strobe decode stays a package function.

Test Plan:
- Read, addr 0x1000_0004, size 10; zero-wait slave returning 0xDEADBEEF → addr_ok the same cycle as req; arvalid the next cycle with araddr 0x1000_0004, arsize 3'b010; data_ok and rdata=0xDEADBEEF 2 cycles after acceptance.
- Write 0x1122_3344 @0x2000_0000, size 10; awready 3 cycles late, wready immediate → W completes first, AW later; exactly one W beat with wstrb 1111; data_ok on the bvalid cycle only.
- Byte write, size 00, addr 0x...3 → wstrb 1000, awsize 000; half write, addr 0x...2 → wstrb 1100.
- Write-back then refill: write followed by a read held on req the cycle after data_ok → both transactions issued in order; no overlap of AW/W with AR.
- rst asserted while in RD_DATA with rvalid low → next cycle arvalid=rready=0, data_ok=0, state IDLE; a later request completes normally.
- With SRAM_AXI_ERR_EN defined, bresp=2'b10 → data_ok pulses and bus_err=1 stays set until rst; without the macro, bus_err stays 0.
